// File: rtl/sc_bs_decoder.sv
// Stochastic/unary bitstream decoder: counts the ones in a frame of FRAME_WORDS
// input words and presents the total through a valid/ready output register.
module sc_bs_decoder #(
  parameter int BS_WIDTH    = 32,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_WIDTH   = $clog2(BS_WIDTH*FRAME_WORDS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [BS_WIDTH-1:0]  bs_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CNT_WIDTH-1:0] cnt_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid/data hold while ready is low; flush overrides any transfer.
  localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WC_W-1:0]      wcnt_q, wcnt_d;
  logic                 live_q;
  logic [CNT_WIDTH-1:0] pop;
  logic                 beat;
  logic                 out_fire;

  always_comb begin
    pop = '0;
    for (int i = 0; i < BS_WIDTH; i++) begin
      pop = pop + CNT_WIDTH'(bs_in[i]);
    end
  end

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_q & (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign cnt_out   = cnt_q;
  assign beat      = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      wcnt_d  = '0;
    end else if (state_q == ST_ACCUM) begin
      if (beat) begin
        if (wcnt_q == LAST_WORD) begin
          cnt_d   = acc_q + pop;
          acc_d   = '0;
          wcnt_d  = '0;
          state_d = ST_HOLD;
        end else begin
          acc_d  = acc_q + pop;
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
    end else if (out_fire) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sc_bs_decoder.sv
// Bench for sc_bs_decoder: default 4-word instance plus a 1-word-frame instance,
// a table of frames, directed corner sequences and a random scoreboard phase.
module tb_sc_bs_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] bs_in;
  logic        in_ready, out_valid;
  logic [7:0]  cnt_out;

  logic        flush1, in_valid1, out_ready1;
  logic [31:0] bs_in1;
  logic        in_ready1, out_valid1;
  logic [5:0]  cnt_out1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] exp_q[$];
  logic [5:0] exp1_q[$];
  int         m_acc, m_words, m_acc1;
  int         sb_frames, sb_frames1;

  typedef struct {
    logic [3:0][31:0] w;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[7];

  sc_bs_decoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bs_in(bs_in), .in_valid(in_valid),
    .in_ready(in_ready), .cnt_out(cnt_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  sc_bs_decoder #(.BS_WIDTH(32), .FRAME_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bs_in(bs_in1), .in_valid(in_valid1),
    .in_ready(in_ready1), .cnt_out(cnt_out1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [7:0] e);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.exp = e;
    return v;
  endfunction

  // scoreboard for the 4-word instance: model accumulates on observed beats
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc = 0; m_words = 0; exp_q.delete();
    end else if (flush) begin
      if (out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      m_acc = 0; m_words = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_queue_depth", 0, 1);
        else begin
          check("sb_cnt_out", {24'd0, cnt_out}, {24'd0, exp_q.pop_front()});
          sb_frames++;
        end
      end
      if (in_valid && in_ready) begin
        m_acc += $countones(bs_in);
        m_words++;
        if (m_words == 4) begin
          exp_q.push_back(m_acc[7:0]);
          m_acc = 0; m_words = 0;
        end
      end
    end
  end

  // scoreboard for the 1-word-frame instance
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc1 = 0; exp1_q.delete();
    end else if (flush1) begin
      if (out_valid1 && exp1_q.size() > 0) void'(exp1_q.pop_front());
    end else begin
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) check("sb1_queue_depth", 0, 1);
        else begin
          check("sb1_cnt_out", {26'd0, cnt_out1}, {26'd0, exp1_q.pop_front()});
          sb_frames1++;
        end
      end
      if (in_valid1 && in_ready1) begin
        m_acc1 = $countones(bs_in1);
        exp1_q.push_back(m_acc1[5:0]);
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic beat(input logic [31:0] w);
    logic acc;
    acc = 1'b0;
    bs_in = w;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    beat(w0); beat(w1); beat(w2); beat(w3);
  endtask

  task automatic wait_out(input string name, input logic [7:0] exp);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        check(name, {24'd0, cnt_out}, {24'd0, exp});
        break;
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bs_in = '0;
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; bs_in1 = '0;
    sb_frames = 0; sb_frames1 = 0;

    vecs[0] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd128);
    vecs[1] = mk(32'h0000FFFF, 32'h00000001, 32'h00000000, 32'h80000000, 8'd18);
    vecs[2] = mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 8'd0);
    vecs[3] = mk(32'hAAAAAAAA, 32'h55555555, 32'hF0F0F0F0, 32'h0F0F0F0F, 8'd64);
    vecs[4] = mk(32'h00000001, 32'h00000003, 32'h00000007, 32'h0000000F, 8'd10);
    vecs[5] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 8'd127);
    vecs[6] = mk(32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 8'd13);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_cnt_out", {24'd0, cnt_out}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready_before_edge", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1 check("rel_in_ready_after_edge", {31'd0, in_ready}, 1);

    // back-to-back all-ones frame: result visible right after the last beat edge
    out_ready = 1'b1;
    frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("lat_out_valid", {31'd0, out_valid}, 1);
    check("lat_cnt_out", {24'd0, cnt_out}, 128);
    check("lat_in_ready_hold", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    check("lat_out_valid_one_cycle", {31'd0, out_valid}, 0);
    check("lat_in_ready_back", {31'd0, in_ready}, 1);

    // table of frames
    for (int i = 0; i < 7; i++) begin
      frame(vecs[i].w[0], vecs[i].w[1], vecs[i].w[2], vecs[i].w[3]);
      wait_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // backpressure: result held stable for 5 cycles
    out_ready = 1'b0;
    frame(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_cnt_out", {24'd0, cnt_out}, 16);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", {31'd0, out_valid}, 0);
    check("bp_release_in_ready", {31'd0, in_ready}, 1);

    // flush mid-frame, with a beat presented in the flush cycle
    beat(32'hFFFFFFFF);
    beat(32'hFFFFFFFF);
    flush = 1'b1; in_valid = 1'b1; bs_in = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accum_in_ready", {31'd0, in_ready}, 1);
    frame(32'h00000003, 32'h00000003, 32'h00000003, 32'h00000003);
    wait_out("flush_accum_result", 8'd8);

    // flush while holding a result
    out_ready = 1'b0;
    frame(32'h000000FF, 32'h00000000, 32'h00000000, 32'h00000000);
    check("flush_hold_pre_valid", {31'd0, out_valid}, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_hold_out_valid", {31'd0, out_valid}, 0);
    check("flush_hold_in_ready", {31'd0, in_ready}, 1);
    check("flush_hold_cnt_kept", {24'd0, cnt_out}, 8);

    // asynchronous reset in the middle of a frame
    beat(32'hFFFFFFFF); beat(32'hFFFFFFFF); beat(32'hFFFFFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 0);
    check("arst_cnt_out", {24'd0, cnt_out}, 0);
    check("arst_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(32'h0000000F, 32'h0000000F, 32'h0000000F, 32'h0000000F);
    wait_out("arst_next_frame", 8'd16);

    // one-word frames complete on every beat
    bs_in1 = 32'hFFFFFFFF; in_valid1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    check("fw1_out_valid", {31'd0, out_valid1}, 1);
    check("fw1_cnt_out", {26'd0, cnt_out1}, 32);
    check("fw1_in_ready", {31'd0, in_ready1}, 0);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;

    // random traffic on both instances against the scoreboards
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0: bs_in = 32'hFFFFFFFF;
        1: bs_in = 32'h0;
        default: bs_in = $urandom;
      endcase
      in_valid1  = ($urandom_range(0, 2) != 0);
      out_ready1 = ($urandom_range(0, 2) != 0);
      flush1     = ($urandom_range(0, 79) == 0);
      bs_in1     = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand1_queue_drained", exp1_q.size(), 0);
    check("rand_frames_seen", {31'd0, sb_frames > 20}, 1);
    check("rand1_frames_seen", {31'd0, sb_frames1 > 100}, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sc_bs_decoder.md
SC_BS_DECODER -- requirements
Module: sc_bs_decoder

Interface
REQ-001 SHALL have parameter BS_WIDTH, default 32, meaning bitstream bits delivered per input word.
REQ-002 SHALL have parameter FRAME_WORDS, default 4, meaning input words per frame (>=1).
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(BS_WIDTH*FRAME_WORDS+1) (8 at defaults), meaning result width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous frame abort.
REQ-007 SHALL have port bs_in  input  BS_WIDTH  unary/stochastic bitstream word, bit 0 first.
REQ-008 SHALL have port in_valid  input  1  bs_in is valid.
REQ-009 SHALL have port in_ready  output  1  decoder accepts bs_in this cycle.
REQ-010 SHALL have port cnt_out  output  CNT_WIDTH  number of ones in the completed frame.
REQ-011 SHALL have port out_valid  output  1  cnt_out is valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes cnt_out.

Function
REQ-013 SHALL implement two states: ACCUM and HOLD.
REQ-014 SHALL drive in_ready = 1 only in ACCUM, and out_valid = 1 only in HOLD.
REQ-015 Input beat SHALL occur when in_valid & in_ready are both high at a rising edge.
REQ-016 On each input beat, SHALL add popcount(bs_in) (0..BS_WIDTH) to the accumulator and increment the word counter.
REQ-017 Popcount SHALL be combinational in the beat cycle; no partial sums are lost or double-counted.
REQ-018 Accumulator width SHALL be CNT_WIDTH; maximum value BS_WIDTH*FRAME_WORDS SHALL be representable without overflow.
REQ-019 On the beat where word counter equals FRAME_WORDS-1: SHALL load cnt_out with accumulator+popcount, clear accumulator and counter, and go to HOLD.
REQ-020 Latency SHALL be 1 cycle: out_valid rises on the edge that accepts the last word.
REQ-021 In HOLD, cnt_out and out_valid SHALL remain stable until out_valid & out_ready are both high.
REQ-022 On output handshake, SHALL return to ACCUM; in_ready SHALL be high the following cycle, with no bubble beyond that one.
REQ-023 Word counter SHALL wrap from FRAME_WORDS-1 to 0; with FRAME_WORDS=1, every beat SHALL complete a frame.
REQ-024 flush=1 in ACCUM SHALL clear accumulator and counter, discard any same-cycle beat, and remain in ACCUM.
REQ-025 flush=1 in HOLD SHALL drop the pending result, return to ACCUM, and clear out_valid.
REQ-026 flush SHALL take priority over all simultaneous beats and handshakes.
REQ-027 cnt_out SHALL hold its last value while in ACCUM; consumers SHALL qualify it with out_valid.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk, force: state=ACCUM, accumulator=0, word counter=0, cnt_out=0, out_valid=0.
REQ-029 in_ready SHALL be 0 while rst_n is low, and 1 from the first rising edge after rst_n deasserts.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next frame SHALL start at word 0.

Verification
REQ-031 Four beats of bs_in=32'hFFFFFFFF with out_ready=1 -> cnt_out=128, out_valid for 1 cycle, 1 cycle after 4th beat.
REQ-032 Beats 32'h0000FFFF, 32'h00000001, 32'h0, 32'h80000000 -> cnt_out=18.
REQ-033 Frame completes with out_ready=0 for 5 cycles -> cnt_out stable, in_ready=0 throughout; after out_ready=1, one handshake, then in_ready=1.
REQ-034 Two beats of 32'hFFFFFFFF, then flush, then four beats of 32'h00000003 -> cnt_out=8.
REQ-035 rst_n pulsed low between clock edges after 3 beats of all-ones -> out_valid=0 and cnt_out=0 immediately; next full frame of 32'h0000000F -> 16.
REQ-036 Random in_valid/out_ready (FRAME_WORDS=1 and default) vs reference popcount model -> every result matches, no frame lost or duplicated.
